// File: rtl/decoder_scan_pkg.sv
// decoder_pkg: shared one-hot helpers and output-width helper for the decoder family
package decoder_pkg;
  function automatic int N_OF(input int sel_w);
    return 1 << sel_w;
  endfunction
  function automatic logic [31:0] onehot(input logic [4:0] sel, input int width);
    return (int'(sel) < width) ? 32'd1 << sel : 32'd0;
  endfunction
  function automatic logic [31:0] apply_level(input logic [31:0] vec, input bit active_low);
    return active_low ? ~vec : vec;
  endfunction
endpackage

// File: rtl/decoder_scan_decoder.sv
// onehot_decoder: combinational enable-gated binary-to-one-hot decoder
module onehot_decoder import decoder_pkg::*; #(
  parameter int SEL_W = 2
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_OF(SEL_W)-1:0]  lines
);
  localparam int N = N_OF(SEL_W);
  assign lines = en ? N'(onehot(5'(sel), N)) : '0;
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with direct select and prescaled scan modes
module decoder_scan import decoder_pkg::*; #(
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic                    hold,
  output logic [N_OF(SEL_W)-1:0]  dec_out,
  output logic [SEL_W-1:0]        idx_out,
  output logic                    wrap_tick
);
  localparam int N = N_OF(SEL_W);
  logic [DIV_W-1:0] pre, pre_nx;
  logic [SEL_W-1:0] idx_nx, dec_sel;
  logic [N-1:0]     lines, dec_nx;
  logic             mode_q, mode_chg, scan_run, step;
  assign mode_chg = mode != mode_q;
  assign scan_run = en & mode & ~mode_chg & ~hold;
  assign step     = scan_run & (&pre);
  onehot_decoder #(.SEL_W(SEL_W)) u_dec (.en(en), .sel(dec_sel), .lines(lines));
  // next prescaler/index and the value the output register loads, in priority order
  always_comb begin
    pre_nx  = !en ? pre : (mode_chg || !mode) ? '0 : hold ? pre : pre + 1'b1;
    idx_nx  = !en ? idx_out : mode_chg ? '0 : !mode ? sel_in : step ? idx_out + 1'b1 : idx_out;
    dec_sel = mode ? idx_nx : sel_in;
    dec_nx  = (en && mode && !mode_chg && hold) ? dec_out : N'(apply_level(32'(lines), ACTIVE_LOW));
  end
  // state and output registers; the whole output vector updates at once so it is never multi-hot
  always_ff @(posedge clk) begin
    if (reset) begin
      pre       <= '0;
      idx_out   <= '0;
      mode_q    <= 1'b0;
      wrap_tick <= 1'b0;
      dec_out   <= {N{ACTIVE_LOW}};
    end else begin
      pre       <= pre_nx;
      idx_out   <= idx_nx;
      mode_q    <= en ? mode : mode_q;
      wrap_tick <= step & (&idx_out);
      dec_out   <= dec_nx;
    end
  end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed plan steps plus randomized run against a behavioural model
module tb_decoder_scan;
  logic       clk = 1'b0;
  logic       reset = 1'b1, en = 1'b0, mode = 1'b0, hold = 1'b0;
  logic [1:0] sel_in = '0;
  logic [3:0] dec_out;
  logic [1:0] idx_out;
  logic       wrap_tick;
  logic       mode_b = 1'b0;
  logic [2:0] sel_b = '0;
  logic [7:0] dec_b;
  logic [2:0] idx_b;
  logic       wrap_b;
  int total = 0, bad = 0;
  int m_pre, m_idx, m_line, m_wrap;
  bit m_modeq, m_act;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .DIV_W(2), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel_in(sel_in), .hold(hold),
    .dec_out(dec_out), .idx_out(idx_out), .wrap_tick(wrap_tick));

  decoder_scan #(.SEL_W(3), .DIV_W(2), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode_b), .sel_in(sel_b), .hold(1'b0),
    .dec_out(dec_b), .idx_out(idx_b), .wrap_tick(wrap_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    chk("reset_dec", 32'(dec_out), 32'h0);
    chk("reset_idx", 32'(idx_out), 32'h0);
    chk("reset_wrap", 32'(wrap_tick), 32'h0);
    chk("reset_dec_b", 32'(dec_b), 32'hFF);
    reset = 1'b0; en = 1'b1; sel_in = 2'd2;
    cyc();
    chk("direct_sel2", 32'(dec_out), 32'h4);
    chk("direct_idx2", 32'(idx_out), 32'h2);
    for (int s = 0; s < 4; s++) begin
      sel_in = 2'(s);
      cyc();
      chk("direct_sweep", 32'(dec_out), 32'h1 << s);
      chk("direct_sweep_idx", 32'(idx_out), 32'(s));
    end
    en = 1'b0; sel_in = 2'd3;
    cyc();
    chk("en_off", 32'(dec_out), 32'h0);
    en = 1'b1;
    cyc();
    chk("en_on", 32'(dec_out), 32'h8);
    mode = 1'b1;
    cyc();
    chk("scan_entry", 32'(dec_out), 32'h1);
    chk("scan_entry_idx", 32'(idx_out), 32'h0);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("scan_line", 32'(dec_out), 32'h1 << ((k / 4) % 4));
      chk("scan_wrap", 32'(wrap_tick), 32'(k % 16 == 0));
    end
    repeat (4) cyc();
    chk("pre_hold_line", 32'(dec_out), 32'h2);
    repeat (2) cyc();
    hold = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("hold_frozen", 32'(dec_out), 32'h2);
      chk("hold_wrap", 32'(wrap_tick), 32'h0);
    end
    hold = 1'b0;
    cyc();
    chk("release_1", 32'(dec_out), 32'h2);
    cyc();
    chk("release_2", 32'(dec_out), 32'h4);
    repeat (4) cyc();
    chk("at_line3", 32'(dec_out), 32'h8);
    mode = 1'b0; sel_in = 2'd1;
    cyc();
    chk("to_direct", 32'(dec_out), 32'h2);
    cyc();
    chk("to_direct_idx", 32'(idx_out), 32'h1);
    mode = 1'b1;
    cyc();
    repeat (5) cyc();
    chk("midscan_line", 32'(dec_out), 32'h2);
    reset = 1'b1;
    cyc();
    chk("midscan_reset_dec", 32'(dec_out), 32'h0);
    chk("midscan_reset_idx", 32'(idx_out), 32'h0);
    reset = 1'b0;
    cyc();
    chk("post_reset_scan", 32'(dec_out), 32'h1);
    chk("post_reset_idx", 32'(idx_out), 32'h0);
    sel_b = 3'd7;
    cyc();
    chk("al_sel7", 32'(dec_b), 32'h7F);
    for (int s = 0; s < 8; s++) begin
      sel_b = 3'(s);
      cyc();
      chk("al_sweep", 32'(dec_b), 32'(8'(~(8'h1 << s))));
      chk("al_one_zero", 32'($countones(~dec_b)), 32'h1);
    end
    reset = 1'b1;
    cyc();
    m_pre = 0; m_idx = 0; m_line = 0; m_wrap = 0; m_modeq = 0; m_act = 0;
    for (int c = 0; c < 600; c++) begin
      reset  = ($urandom_range(0, 99) < 2);
      en     = ($urandom_range(0, 99) < 90);
      hold   = ($urandom_range(0, 99) < 20);
      sel_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4) mode = ~mode;
      cyc();
      m_wrap = 0;
      if (reset) begin
        m_pre = 0; m_idx = 0; m_modeq = 0; m_act = 0;
      end else if (!en) begin
        m_act = 0;
      end else if (mode != m_modeq) begin
        m_pre = 0; m_idx = 0; m_modeq = mode; m_act = 1;
        m_line = mode ? 0 : int'(sel_in);
      end else if (!mode) begin
        m_pre = 0; m_idx = int'(sel_in); m_line = m_idx; m_act = 1;
      end else if (!hold) begin
        m_pre++;
        if (m_pre == 4) begin
          m_pre = 0;
          m_idx = (m_idx + 1) % 4;
          m_wrap = (m_idx == 0);
        end
        m_line = m_idx; m_act = 1;
      end
      chk("rand_dec", 32'(dec_out), m_act ? 32'h1 << m_line : 32'h0);
      chk("rand_idx", 32'(idx_out), 32'(m_idx));
      chk("rand_wrap", 32'(wrap_tick), 32'(m_wrap));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
